// File: rtl/jk_counter_reg_if.sv
// Control and data bundle for the JK counter register bank.
// Master drives the controls and observes Q/nQ/TC; slave is the register bank.
interface jk_counter_reg_if #(
    parameter int WIDTH = 8
);
    logic             S;
    logic             EN;
    logic [1:0]       MODE;
    logic [WIDTH-1:0] J;
    logic [WIDTH-1:0] K;
    logic [WIDTH-1:0] D;
    logic             CI;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] nQ;
    logic             TC;

    modport master (
        output S, EN, MODE, J, K, D, CI,
        input  Q, nQ, TC
    );

    modport slave (
        input  S, EN, MODE, J, K, D, CI,
        output Q, nQ, TC
    );
endinterface

// File: rtl/jk_counter_reg.sv
// Bank of JK triggers with D-load and cascadable up/down counting.
// Priority at each rising C: R, then S, then EN, then MODE.
module jk_counter_reg #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             C,
    input  logic             R,
    jk_counter_reg_if.slave  bus
);

    typedef enum logic [1:0] {
        MODE_JK   = 2'b00,
        MODE_LOAD = 2'b01,
        MODE_UP   = 2'b10,
        MODE_DOWN = 2'b11
    } mode_t;

    localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZEROS = {WIDTH{1'b0}};

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] next_q_s;
    logic [WIDTH-1:0] up_mask_s;
    logic [WIDTH-1:0] down_mask_s;
    logic             at_terminal_s;
    logic             tc_s;
    mode_t            mode_s;

    // Bit i toggles when the carry reaches it: ci and every lower bit set.
    function automatic logic [WIDTH-1:0] up_toggle_mask(
        input logic [WIDTH-1:0] q,
        input logic             ci
    );
        logic [WIDTH-1:0] mask;
        mask    = {WIDTH{1'b0}};
        mask[0] = ci;
        for (int i = 1; i < WIDTH; i++) begin
            mask[i] = mask[i-1] & q[i-1];
        end
        return mask;
    endfunction

    // Borrow chain: bit i toggles when ci and every lower bit clear.
    function automatic logic [WIDTH-1:0] down_toggle_mask(
        input logic [WIDTH-1:0] q,
        input logic             ci
    );
        logic [WIDTH-1:0] mask;
        mask    = {WIDTH{1'b0}};
        mask[0] = ci;
        for (int i = 1; i < WIDTH; i++) begin
            mask[i] = mask[i-1] & ~q[i-1];
        end
        return mask;
    endfunction

    // Classic JK characteristic equation applied bitwise.
    function automatic logic [WIDTH-1:0] jk_next(
        input logic [WIDTH-1:0] q,
        input logic [WIDTH-1:0] j,
        input logic [WIDTH-1:0] k
    );
        return (j & ~q) | (~k & q);
    endfunction

    assign mode_s = mode_t'(bus.MODE);

    // Toggle masks for the T-trigger count chain.
    always_comb begin
        up_mask_s   = up_toggle_mask(q_r, bus.CI);
        down_mask_s = down_toggle_mask(q_r, bus.CI);
    end

    // Next state for an enabled edge; R and S are resolved in the register.
    always_comb begin
        next_q_s = q_r;
        if (bus.EN) begin
            case (mode_s)
                MODE_JK:   next_q_s = jk_next(q_r, bus.J, bus.K);
                MODE_LOAD: next_q_s = bus.D;
                MODE_UP:   next_q_s = q_r ^ up_mask_s;
                MODE_DOWN: next_q_s = q_r ^ down_mask_s;
                default:   next_q_s = q_r;
            endcase
        end else begin
            next_q_s = q_r;
        end
    end

    // State register with synchronous reset and preset.
    always_ff @(posedge C) begin
        if (R) begin
            q_r <= RESET_VALUE;
        end else if (bus.S) begin
            q_r <= ALL_ONES;
        end else begin
            q_r <= next_q_s;
        end
    end

    // Terminal count is combinational so cascaded CI->TC ripples within a cycle.
    always_comb begin
        if (bus.MODE[0]) begin
            at_terminal_s = (q_r == ALL_ZEROS);
        end else begin
            at_terminal_s = (q_r == ALL_ONES);
        end
        tc_s = bus.EN & bus.CI & ~R & ~bus.S & bus.MODE[1] & at_terminal_s;
    end

    assign bus.Q  = q_r;
    assign bus.nQ = ~q_r;
    assign bus.TC = tc_s;

endmodule
